count_step_monitor: RTL and testbench

// - Downstream consumer of the 8-bit jerky counter output; samples count each clock it is valid.
// - Computes the modulo-256 step between successive samples and classifies it: stall, unit step, jump or restart.
// - Keeps saturating statistics and a sticky error flag when a step exceeds the allowed size.
// - Gives benches and later HW stages a checked, self-describing view of the counter pattern.

---
 rtl/count_mon_pkg.sv | 25 ++
 rtl/sat_counter.sv | 39 +++
 rtl/count_step_monitor.sv | 177 +++++++++++++++++
 tb/tb_count_step_monitor.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/count_mon_pkg.sv
// Shared types and default widths for the count step monitor.
//   mon_state_t : monitor FSM states
//   step_cls_t  : classification of one observed step (encoding is visible on step_cls)
package count_mon_pkg;

    localparam int unsigned CW_DEF        = 8;
    localparam int unsigned MAX_STEP_DEF  = 8;
    localparam int unsigned STAT_W_DEF    = 16;
    localparam int unsigned STALL_LIM_DEF = 4;
    localparam int unsigned RUN_W         = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        ERR   = 2'd2
    } mon_state_t;

    typedef enum logic [1:0] {
        STALL   = 2'd0,
        UNIT    = 2'd1,
        JUMP    = 2'd2,
        RESTART = 2'd3
    } step_cls_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   inc          : count up by one unless already all-ones
//   clr          : synchronous clear, wins over inc
//   q            : current count
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc && (q_q != '1)) begin
            q_d = q_q + W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/count_step_monitor.sv
// Observes a counter stream and classifies the modulo-2^CW step between
// successive valid samples as STALL, UNIT, JUMP or RESTART, with saturating
// statistics and a sticky error for forward jumps larger than MAX_STEP.
// Optional feature macro: STALL_TIMEOUT_EN (adds the consecutive-stall
// detector driving stalled; without it stalled is tied low).
// Ports:
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   count_in     : observed counter value, qualified by count_valid
//   clr_stats    : synchronous clear of statistics and err
//   step_out     : last step, (count_in - prev) mod 2^CW
//   step_valid   : one-cycle pulse when step_out/step_cls update
//   step_cls     : 0 STALL, 1 UNIT, 2 JUMP, 3 RESTART
//   run_len      : consecutive UNIT steps, saturating
//   jump_cnt     : JUMP steps seen, saturating
//   restart_cnt  : RESTART events seen, saturating
//   err          : sticky illegal-step flag
//   stalled      : STALL_LIM consecutive STALL steps seen
module count_step_monitor
    import count_mon_pkg::*;
#(
    parameter int unsigned CW        = CW_DEF,
    parameter int unsigned MAX_STEP  = MAX_STEP_DEF,
`ifdef STALL_TIMEOUT_EN
    parameter int unsigned STALL_LIM = STALL_LIM_DEF,
`endif
    parameter int unsigned STAT_W    = STAT_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [CW-1:0]     count_in,
    input  logic              count_valid,
    input  logic              clr_stats,
    output logic [CW-1:0]     step_out,
    output logic              step_valid,
    output logic [1:0]        step_cls,
    output logic [RUN_W-1:0]  run_len,
    output logic [STAT_W-1:0] jump_cnt,
    output logic [STAT_W-1:0] restart_cnt,
    output logic              err,
    output logic              stalled
);

    mon_state_t    state_q, state_d;
    logic [CW-1:0] prev_q, prev_d;
    logic [CW-1:0] step_q, step_d;
    step_cls_t     cls_q, cls_d;
    logic          step_valid_q, step_valid_d;
    logic          err_q, err_d;

    logic [CW-1:0] step_raw;
    step_cls_t     cls_now;
    logic          fire;
    logic          illegal;

    assign step_raw = count_in - prev_q;
    assign fire     = count_valid && (state_q != IDLE);

    // Restart check comes first so that a wrap to zero is never seen as a step.
    always_comb begin
        if ((count_in == '0) && (prev_q != '0)) begin
            cls_now = RESTART;
        end else if (step_raw == '0) begin
            cls_now = STALL;
        end else if (step_raw == CW'(1)) begin
            cls_now = UNIT;
        end else begin
            cls_now = JUMP;
        end
    end

    assign illegal = (cls_now == JUMP) && (step_raw > CW'(MAX_STEP));

    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        step_d       = step_q;
        cls_d        = cls_q;
        step_valid_d = 1'b0;
        err_d        = err_q;

        case (state_q)
            IDLE: begin
                if (count_valid) begin
                    prev_d  = count_in;
                    state_d = TRACK;
                end
            end
            TRACK, ERR: begin
                if (count_valid) begin
                    prev_d       = count_in;
                    step_d       = step_raw;
                    cls_d        = cls_now;
                    step_valid_d = 1'b1;
                    if (illegal) begin
                        err_d   = 1'b1;
                        state_d = ERR;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Clear beats a simultaneous illegal step, so err and ERR stay consistent.
        if (clr_stats) begin
            err_d = 1'b0;
            if (state_d == ERR) begin
                state_d = TRACK;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            prev_q       <= '0;
            step_q       <= '0;
            cls_q        <= STALL;
            step_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            step_q       <= step_d;
            cls_q        <= cls_d;
            step_valid_q <= step_valid_d;
            err_q        <= err_d;
        end
    end

    sat_counter #(.W(RUN_W)) u_run_len (
        .clock (clock),
        .reset (reset),
        .inc   (fire && (cls_now == UNIT)),
        .clr   (clr_stats || (fire && ((cls_now == JUMP) || (cls_now == RESTART)))),
        .q     (run_len)
    );

    sat_counter #(.W(STAT_W)) u_jump_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (fire && (cls_now == JUMP)),
        .clr   (clr_stats),
        .q     (jump_cnt)
    );

    sat_counter #(.W(STAT_W)) u_restart_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (fire && (cls_now == RESTART)),
        .clr   (clr_stats),
        .q     (restart_cnt)
    );

`ifdef STALL_TIMEOUT_EN
    logic [7:0] stall_cnt;

    sat_counter #(.W(8)) u_stall_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (fire && (cls_now == STALL)),
        .clr   (clr_stats || (fire && (cls_now != STALL))),
        .q     (stall_cnt)
    );

    assign stalled = (stall_cnt >= 8'(STALL_LIM));
`else
    assign stalled = 1'b0;
`endif

    assign step_out   = step_q;
    assign step_cls   = cls_q;
    assign step_valid = step_valid_q;
    assign err        = err_q;

endmodule

// File: tb/tb_count_step_monitor.sv
module tb_count_step_monitor;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  count_in;
    logic        count_valid;
    logic        clr_stats;
    logic [7:0]  step_out;
    logic        step_valid;
    logic [1:0]  step_cls;
    logic [7:0]  run_len;
    logic [15:0] jump_cnt;
    logic [15:0] restart_cnt;
    logic        err;
    logic        stalled;

    count_step_monitor dut (
        .clock       (clock),
        .reset       (reset),
        .count_in    (count_in),
        .count_valid (count_valid),
        .clr_stats   (clr_stats),
        .step_out    (step_out),
        .step_valid  (step_valid),
        .step_cls    (step_cls),
        .run_len     (run_len),
        .jump_cnt    (jump_cnt),
        .restart_cnt (restart_cnt),
        .err         (err),
        .stalled     (stalled)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    // Reference model: state after the next rising edge.
    bit have_prev;
    int m_prev, m_step, m_cls, m_pulse, m_run, m_jump, m_restart, m_err, m_stall_run, m_stalled;

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        have_prev = 1'b0;
        m_prev = 0; m_step = 0; m_cls = 0; m_pulse = 0;
        m_run = 0; m_jump = 0; m_restart = 0; m_err = 0;
        m_stall_run = 0; m_stalled = 0;
    endtask

    task automatic model_step(input bit v, input int c, input bit clr);
        int s;
        m_pulse = 0;
        if (v) begin
            if (!have_prev) begin
                have_prev = 1'b1;
            end else begin
                s = (c - m_prev + 256) % 256;
                m_step  = s;
                m_pulse = 1;
                if (c == 0 && m_prev != 0) begin
                    m_cls = 3;
                    if (m_restart < 65535) m_restart++;
                    m_run = 0;
                end else if (s == 0) begin
                    m_cls = 0;
                end else if (s == 1) begin
                    m_cls = 1;
                    if (m_run < 255) m_run++;
                end else begin
                    m_cls = 2;
                    if (m_jump < 65535) m_jump++;
                    m_run = 0;
                    if (s > 8) m_err = 1;
                end
                if (m_cls == 0) m_stall_run++;
                else m_stall_run = 0;
            end
            m_prev = c;
        end
        if (clr) begin
            m_run = 0; m_jump = 0; m_restart = 0; m_err = 0; m_stall_run = 0;
        end
`ifdef STALL_TIMEOUT_EN
        m_stalled = (m_stall_run >= 4) ? 1 : 0;
`else
        m_stalled = 0;
`endif
    endtask

    // Per-cycle compare against the model, just after each rising edge.
    always @(posedge clock) begin
        if (chk_on) begin
            #2;
            chk("step_valid", step_valid, m_pulse);
            chk("step_out", step_out, m_step);
            chk("step_cls", step_cls, m_cls);
            chk("run_len", run_len, m_run);
            chk("jump_cnt", jump_cnt, m_jump);
            chk("restart_cnt", restart_cnt, m_restart);
            chk("err", err, m_err);
            chk("stalled", stalled, m_stalled);
        end
    end

    task automatic apply(input bit v, input int c, input bit clr);
        @(negedge clock);
        count_valid = v;
        count_in    = 8'(c);
        clr_stats   = clr;
        model_step(v, c, clr);
    endtask

    task automatic settle();
        @(posedge clock);
        #3;
    endtask

    task automatic do_reset();
        @(negedge clock);
        count_valid = 1'b0; count_in = 8'd0; clr_stats = 1'b0;
        reset = 1'b1;
        model_reset();
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        count_valid = 1'b0; count_in = 8'd0; clr_stats = 1'b0;
        model_reset();
        chk_on = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;

        // First sample silent, then three unit steps.
        apply(1, 0, 0); apply(1, 1, 0); apply(1, 2, 0); apply(1, 3, 0);
        settle();
        chk("lit_run_len_3", run_len, 3);
        chk("lit_err_0", err, 0);

        // Legal jumps, then an illegal one.
        do_reset();
        apply(1, 5, 0); apply(1, 9, 0); apply(1, 17, 0);
        settle();
        chk("lit_jump_cnt_2", jump_cnt, 2);
        chk("lit_err_still_0", err, 0);
        apply(1, 30, 0);
        settle();
        chk("lit_err_1", err, 1);
        chk("lit_step_13", step_out, 13);

        // Restart while in error, idle cycles in between.
        apply(1, 120, 0); apply(1, 0, 0);
        settle();
        chk("lit_restart_1", restart_cnt, 1);
        chk("lit_restart_cls", step_cls, 3);
        apply(0, 77, 0); apply(0, 77, 0);

        // Wrap region: 255->0 is a restart, 255->3 is a legal jump of 4.
        apply(1, 254, 0); apply(1, 255, 0); apply(1, 0, 0); apply(1, 255, 0); apply(1, 3, 0);
        settle();
        chk("lit_wrap_step_4", step_out, 4);

        // Clear statistics alone, then clear together with a sample.
        apply(0, 0, 1);
        settle();
        chk("lit_clr_err", err, 0);
        chk("lit_clr_jump", jump_cnt, 0);
        apply(1, 4, 1);
        settle();
        chk("lit_clr_sample_step", step_out, 1);
        chk("lit_clr_sample_run", run_len, 0);

        // 250 -> 2 is a step of 8: legal at the boundary.
        apply(1, 250, 0); apply(0, 0, 1); apply(1, 2, 0);
        settle();
        chk("lit_mod_step_8", step_out, 8);
        chk("lit_mod_err_0", err, 0);
        apply(1, 11, 0);
        settle();
        chk("lit_step_9_err", err, 1);
        apply(0, 0, 1);

        // Held value: stall detection.
        apply(1, 7, 0); apply(1, 7, 0); apply(1, 7, 0); apply(1, 7, 0);
        settle();
        chk("lit_three_stalls", stalled, 0);
        apply(1, 7, 0);
        settle();
`ifdef STALL_TIMEOUT_EN
        chk("lit_stalled_on", stalled, 1);
`else
        chk("lit_stalled_off", stalled, 0);
`endif
        apply(1, 7, 0); apply(1, 8, 0);
        settle();
        chk("lit_stall_cleared", stalled, 0);
        chk("lit_unit_after_stall", step_cls, 1);

        // Asynchronous reset between edges.
        apply(1, 9, 0);
        @(negedge clock);
        count_valid = 1'b0;
        model_step(0, 0, 0);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("lit_async_run", run_len, 0);
        chk("lit_async_step", step_out, 0);
        chk("lit_async_valid", step_valid, 0);
        #1;
        reset = 1'b0;
        apply(1, 10, 0);
        settle();
        chk("lit_first_after_reset", step_valid, 0);
        apply(1, 11, 0);
        settle();
        chk("lit_second_after_reset", step_valid, 1);

        apply(0, 0, 0);
        repeat (2) @(negedge clock);
        chk_on = 1'b0;
        #10;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
